// File: rtl/lf_multiword_add_seq.sv
// rtl/lf_multiword_add_seq.sv - wide adder sequencer time-multiplexing one 8-bit adder
module lf_multiword_add_seq #(
    parameter int WORDS = 4,
    localparam int W = 8 * WORDS,
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_cout,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    output logic             add_cin,
    input  logic [8:0]       add_sum,
    output logic             busy,
    output logic [IDX_W-1:0] slice_idx
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    logic [1:0]       state;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     sum_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;

    assign out_sum   = sum_reg;
    assign busy      = (state != S_IDLE);
    assign slice_idx = idx;

    // Present the current slice to the adder only while running; zero otherwise
    // so idle-time garbage on the operand inputs never reaches the adder.
    always_comb begin
        add_a   = 8'h00;
        add_b   = 8'h00;
        add_cin = 1'b0;
        if (state == S_RUN) begin
            add_cin = carry_reg;
            for (int i = 0; i < WORDS; i++) begin
                if (idx == IDX_W'(i)) begin
                    add_a = a_reg[8*i +: 8];
                    add_b = b_reg[8*i +: 8];
                end
            end
        end
    end

    // Sequencer: accept, ripple one slice per cycle, then hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!in_ready) begin
                        in_ready <= 1'b1;
                    end else if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        carry_reg <= in_cin;
                        idx       <= '0;
                        in_ready  <= 1'b0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (idx == IDX_W'(i)) begin
                            sum_reg[8*i +: 8] <= add_sum[7:0];
                        end
                    end
                    carry_reg <= add_sum[8];
                    if (idx == LAST_IDX) begin
                        out_cout  <= add_sum[8];
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lf_multiword_add_seq.sv
// tb/tb_lf_multiword_add_seq.sv - self-checking bench for lf_multiword_add_seq
module tb_lf_multiword_add_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic        out_cout;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [8:0]  add_sum;
    logic        busy;
    logic [1:0]  slice_idx;

    logic        in_valid_1 = 1'b0;
    logic        in_ready_1;
    logic [7:0]  in_a_1 = '0;
    logic [7:0]  in_b_1 = '0;
    logic        in_cin_1 = 1'b0;
    logic        out_valid_1;
    logic        out_ready_1 = 1'b0;
    logic [7:0]  out_sum_1;
    logic        out_cout_1;
    logic [7:0]  add_a_1;
    logic [7:0]  add_b_1;
    logic        add_cin_1;
    logic [8:0]  add_sum_1;
    logic        busy_1;
    logic [0:0]  slice_idx_1;

    int n_checks = 0;
    int n_fail = 0;
    logic [32:0] q[$];

    always #5 clk = ~clk;

    // Behavioural stand-ins for the 8-bit adder instances.
    assign add_sum   = {1'b0, add_a} + {1'b0, add_b} + 9'(add_cin);
    assign add_sum_1 = {1'b0, add_a_1} + {1'b0, add_b_1} + 9'(add_cin_1);

    lf_multiword_add_seq #(.WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
        .busy(busy), .slice_idx(slice_idx)
    );

    lf_multiword_add_seq #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_1), .in_ready(in_ready_1), .in_a(in_a_1), .in_b(in_b_1), .in_cin(in_cin_1),
        .out_valid(out_valid_1), .out_ready(out_ready_1), .out_sum(out_sum_1), .out_cout(out_cout_1),
        .add_a(add_a_1), .add_b(add_b_1), .add_cin(add_cin_1), .add_sum(add_sum_1),
        .busy(busy_1), .slice_idx(slice_idx_1)
    );

    // Drive one op into dut4 starting at a negedge; returns at the negedge where out_valid is seen.
    task automatic do_op4(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          output int lat, output logic [3:0] cseen, output logic ok);
        int t;
        t = 0; ok = 1'b1; cseen = 4'b0000; lat = 0;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(posedge clk); @(negedge clk); t++;
        end
        if (!in_ready) begin
            ok = 1'b0; in_valid = 1'b0;
            return;
        end
        q.push_back({1'b0, a} + {1'b0, b} + 33'(cin));
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin
            if (busy) cseen[slice_idx] = add_cin;
            @(posedge clk); @(negedge clk); lat++;
        end
        if (!out_valid) ok = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, out_cout, add_cin} !== 5'b0 || out_sum !== 32'h0 ||
            add_a !== 8'h0 || add_b !== 8'h0 || slice_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b vld=%b busy=%b sum=%h cout=%b add=%h/%h/%b idx=%0d, required all zero",
                     in_ready, out_valid, busy, out_sum, out_cout, add_a, add_b, add_cin, slice_idx);
        end
        repeat (2) @(negedge clk);
        in_a = 'x; in_b = 'x;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_before_edge: got %b required 0", in_ready);
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || in_ready_1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after_edge: got %b/%b required 1/1", in_ready, in_ready_1);
        end
        n_checks++;
        if (add_a !== 8'h0 || add_b !== 8'h0 || add_cin !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_adder_zero: got %h/%h/%b required 00/00/0", add_a, add_b, add_cin);
        end
        in_a = '0; in_b = '0;
    endtask

    task automatic test_carry_chain;
        int lat; logic [3:0] cs; logic ok; logic [32:0] exp;
        do_op4(32'h000000FF, 32'h00000001, 1'b0, lat, cs, ok);
        n_checks++;
        if (!ok || lat != 4) begin
            n_fail++;
            $display("FAIL carry_latency: got %0d ok=%b required 4", lat, ok);
        end
        n_checks++;
        if (cs !== 4'b0010) begin
            n_fail++;
            $display("FAIL carry_slice_cin: got %b required 0010", cs);
        end
        out_ready = 1'b1;
        exp = q.pop_front();
        n_checks++;
        if ({out_cout, out_sum} !== exp || exp !== 33'h000000100) begin
            n_fail++;
            $display("FAIL carry_result: got %h required %h", {out_cout, out_sum}, 33'h000000100);
        end
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_ripple;
        int lat; logic [3:0] cs; logic ok; logic [32:0] exp;
        do_op4(32'hFFFFFFFF, 32'h00000000, 1'b1, lat, cs, ok);
        n_checks++;
        if (!ok || cs !== 4'b1111) begin
            n_fail++;
            $display("FAIL ripple_cin: got %b ok=%b required 1111", cs, ok);
        end
        out_ready = 1'b1;
        exp = q.pop_front();
        n_checks++;
        if ({out_cout, out_sum} !== exp || exp !== 33'h100000000) begin
            n_fail++;
            $display("FAIL ripple_result: got %h required %h", {out_cout, out_sum}, 33'h100000000);
        end
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int lat; logic [3:0] cs; logic ok; logic [32:0] exp; int bad;
        do_op4(32'h89ABCDEF, 32'h76543210, 1'b1, lat, cs, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_start: op did not complete, ok=%b required 1", ok);
        end
        exp = q.pop_front();
        bad = 0;
        in_a = 32'h11111111; in_b = 32'h22222222;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            @(posedge clk); @(negedge clk);
            if ({out_cout, out_sum} !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d unstable cycles, required 0 (sum=%h vld=%b rdy=%b)",
                     bad, {out_cout, out_sum}, out_valid, in_ready);
        end
        out_ready = 1'b1;
        n_checks++;
        if ({out_cout, out_sum} !== exp || exp !== 33'h100000000) begin
            n_fail++;
            $display("FAIL bp_result: got %h required %h", {out_cout, out_sum}, 33'h100000000);
        end
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: rdy=%b busy=%b vld=%b required 1/0/0", in_ready, busy, out_valid);
        end
        do_op4(32'h00000005, 32'h00000007, 1'b0, lat, cs, ok);
        out_ready = 1'b1;
        exp = q.pop_front();
        n_checks++;
        if (!ok || {out_cout, out_sum} !== exp) begin
            n_fail++;
            $display("FAIL bp_next_op: got %h ok=%b required %h", {out_cout, out_sum}, ok, exp);
        end
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int t; int lat; logic [3:0] cs; logic ok; logic [32:0] exp;
        in_a = 32'hFFFFFFFF; in_b = 32'h00000001; in_cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!(busy && slice_idx == 2'd2) && t < 20) begin
            @(posedge clk); @(negedge clk); t++;
        end
        n_checks++;
        if (!(busy && slice_idx == 2'd2)) begin
            n_fail++;
            $display("FAIL midrst_reach: busy=%b idx=%0d required 1/2", busy, slice_idx);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, out_cout, add_cin} !== 5'b0 || out_sum !== 32'h0 ||
            add_a !== 8'h0 || add_b !== 8'h0 || slice_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_async: rdy=%b vld=%b busy=%b sum=%h cout=%b add=%h/%h/%b idx=%0d, required all zero",
                     in_ready, out_valid, busy, out_sum, out_cout, add_a, add_b, add_cin, slice_idx);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_ready_low: got %b required 0", in_ready);
        end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ready_high: got %b required 1", in_ready);
        end
        do_op4(32'h12345678, 32'h11111111, 1'b0, lat, cs, ok);
        out_ready = 1'b1;
        exp = q.pop_front();
        n_checks++;
        if (!ok || {out_cout, out_sum} !== exp || exp !== 33'h023456789) begin
            n_fail++;
            $display("FAIL midrst_followup: got %h ok=%b required %h", {out_cout, out_sum}, ok, 33'h023456789);
        end
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_words1;
        int t; int lat; logic [32:0] exp;
        in_a_1 = 8'h80; in_b_1 = 8'h80; in_cin_1 = 1'b0; in_valid_1 = 1'b1;
        t = 0;
        while (!in_ready_1 && t < 20) begin
            @(posedge clk); @(negedge clk); t++;
        end
        q.push_back(33'(9'h080 + 9'h080));
        @(posedge clk); @(negedge clk);
        in_valid_1 = 1'b0;
        lat = 0;
        while (!out_valid_1 && lat < 20) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        n_checks++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL w1_latency: got %0d required 1", lat);
        end
        out_ready_1 = 1'b1;
        exp = q.pop_front();
        n_checks++;
        if (33'({out_cout_1, out_sum_1}) !== exp || slice_idx_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL w1_result: got %h idx=%b required %h idx=0", {out_cout_1, out_sum_1}, slice_idx_1, exp);
        end
        @(posedge clk); @(negedge clk);
        out_ready_1 = 1'b0;
        n_checks++;
        if (in_ready_1 !== 1'b1 || out_valid_1 !== 1'b0) begin
            n_fail++;
            $display("FAIL w1_release: rdy=%b vld=%b required 1/0", in_ready_1, out_valid_1);
        end
    endtask

    task automatic test_random;
        int sent; int got; int cyc; int gap; logic have; logic [32:0] exp;
        sent = 0; got = 0; cyc = 0; gap = 0; have = 1'b0;
        while (got < 500 && cyc < 20000) begin
            if (!have && sent < 500) begin
                have = 1'b1;
                in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom_range(0, 1));
                gap = $urandom_range(0, 3);
            end
            if (have && gap == 0) in_valid = 1'b1;
            else begin
                in_valid = 1'b0;
                if (gap > 0) gap--;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) begin
                q.push_back({1'b0, in_a} + {1'b0, in_b} + 33'(in_cin));
                have = 1'b0; sent++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_dup: result %h with no outstanding op", {out_cout, out_sum});
                end else begin
                    exp = q.pop_front();
                    if ({out_cout, out_sum} !== exp) begin
                        n_fail++;
                        $display("FAIL rand_result[%0d]: got %h required %h", got, {out_cout, out_sum}, exp);
                    end
                end
                got++;
            end
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0;
            cyc++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (got != 500 || sent != 500 || q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count: sent=%0d got=%0d pending=%0d required 500/500/0", sent, got, q.size());
        end
    endtask

    initial begin
        test_reset;
        test_carry_chain;
        test_ripple;
        test_backpressure;
        test_reset_mid;
        test_words1;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
